encoder_8_3_seq: RTL and testbench

- Sequential 8-to-3 priority encoder: the inverse of the 3-to-8 decoder.
- Latches strobed request lines into a pending register.
- Emits one 3-bit code per pending request, highest priority first.
- Codes are delivered over a valid/ready handshake to a downstream consumer, e.g. a decoder_3_8 driving selects.

---
 rtl/encoder_8_3_seq.sv | 98 +++++++++
 tb/tb_encoder_8_3_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/encoder_8_3_seq.sv
// Sequential priority encoder: latches request strobes into a pending
// vector and drains them one code per cycle over a valid/ready handshake.
module encoder_8_3_seq #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 3,
  parameter int PRIO_HIGH = 1
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             E,
  input  logic [IN_W-1:0]  In,
  input  logic             Rdy,
  output logic [OUT_W-1:0] Out,
  output logic             V,
  output logic [IN_W-1:0]  Pend,
  output logic             Ovf
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_next;
  logic [IN_W-1:0]  arr, elig, held, load_mask;
  logic [OUT_W-1:0] sel, out_next;
  logic             load, v_next, any;

  assign arr = E ? In : '0;
  assign any = |elig;

  always_comb begin
    held = '0;
    if (V) held[Out] = 1'b1;
  end

  // A request re-arriving on a transfer cycle must not be reissued at once
  always_comb begin
    elig = Pend;
    if (state == HOLD) elig = Pend & ~arr;
  end

  always_comb begin
    sel = '0;
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < IN_W; i++)
        if (elig[i]) sel = OUT_W'(i);
    end else begin
      for (int i = IN_W-1; i >= 0; i--)
        if (elig[i]) sel = OUT_W'(i);
    end
  end

  always_ff @(posedge clka) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (any) state_next = HOLD;
      HOLD: if (Rdy && !any) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    v_next = V;
    unique case (state)
      IDLE: begin
        load   = any;
        v_next = any;
      end
      HOLD: begin
        load = Rdy && any;
        if (Rdy) v_next = any;
      end
      default: v_next = 1'b0;
    endcase
    out_next  = load ? sel : Out;
    load_mask = '0;
    if (load) load_mask[sel] = 1'b1;
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      Pend <= '0;
      Out  <= '0;
      V    <= 1'b0;
      Ovf  <= 1'b0;
    end else begin
      Pend <= (Pend & ~load_mask) | arr;
      Out  <= out_next;
      V    <= v_next;
      Ovf  <= |(arr & (Pend | held));
    end
  end

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Bench for encoder_8_3_seq: directed vectors, queue scoreboard on
// every V&&Rdy transfer plus direct register checks.
module tb_encoder_8_3_seq;

  logic       clka = 1'b0;
  logic       rst  = 1'b1;
  logic       E    = 1'b0;
  logic [7:0] In   = '0;
  logic       Rdy  = 1'b0;
  logic [2:0] Out;
  logic       V;
  logic [7:0] Pend;
  logic       Ovf;

  int checks = 0;
  int errors = 0;
  logic [2:0] q[$];

  encoder_8_3_seq #(.IN_W(8), .OUT_W(3), .PRIO_HIGH(1)) dut (
    .clka(clka), .rst(rst), .E(E), .In(In), .Rdy(Rdy),
    .Out(Out), .V(V), .Pend(Pend), .Ovf(Ovf)
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // Monitor: each accepted code must match the next expected one
  always @(negedge clka) begin
    if (V === 1'b1 && Rdy === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got code %0d expected none", Out);
      end else begin
        logic [2:0] e;
        e = q.pop_front();
        if (Out !== e) begin
          errors++;
          $display("FAIL sb_code: got %0d expected %0d", Out, e);
        end
      end
    end
  end

  initial begin
    // 1: reset ignores inputs
    rst = 1; E = 1; In = 8'hFF; Rdy = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_v", V, 0);
      chk("rst_out", Out, 0);
      chk("rst_pend", Pend, 8'h00);
      chk("rst_ovf", Ovf, 0);
    end
    rst = 0; In = 8'h00;
    tick(); tick();
    chk("post_rst_v", V, 0);

    // 2: single request latency
    In = 8'h20;
    tick();
    chk("s_pend_k1", Pend, 8'h20);
    chk("s_v_k1", V, 0);
    In = 8'h00;
    q.push_back(3'd5);
    tick();
    chk("s_v_k2", V, 1);
    chk("s_out_k2", Out, 5);
    chk("s_pend_k2", Pend, 8'h00);
    tick();
    chk("s_v_k3", V, 0);

    // 3: multi-drain, highest first
    In = 8'h91;
    q.push_back(3'd7); q.push_back(3'd4); q.push_back(3'd0);
    tick();
    chk("m_pend", Pend, 8'h91);
    In = 8'h00;
    tick();
    chk("m_out7", Out, 7);
    chk("m_pend7", Pend, 8'h11);
    tick();
    chk("m_out4", Out, 4);
    tick();
    chk("m_out0", Out, 0);
    chk("m_v0", V, 1);
    tick();
    chk("m_v_end", V, 0);
    chk("m_pend_end", Pend, 8'h00);

    // 4: backpressure, no preemption
    Rdy = 0; In = 8'h06;
    q.push_back(3'd2); q.push_back(3'd7); q.push_back(3'd1);
    tick();
    In = 8'h00;
    tick();
    chk("b_out", Out, 2);
    chk("b_v", V, 1);
    tick();
    In = 8'h80;
    tick();
    In = 8'h00;
    chk("b_pend", Pend, 8'h82);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_hold", {V, Out}, {1'b1, 3'd2});
    end
    Rdy = 1;
    tick(); tick(); tick();
    chk("b_drain_v", V, 0);

    // 5: duplicate request and enable gating
    Rdy = 0; In = 8'h10;
    q.push_back(3'd4); q.push_back(3'd3);
    tick();
    In = 8'h00;
    tick();
    chk("d_out4", Out, 4);
    In = 8'h08;
    tick();
    chk("d_ovf_first", Ovf, 0);
    tick();
    In = 8'h00;
    chk("d_ovf_dup", Ovf, 1);
    tick();
    chk("d_ovf_once", Ovf, 0);
    chk("d_pend", Pend, 8'h08);
    E = 0; In = 8'hFF;
    tick();
    chk("e_pend", Pend, 8'h08);
    chk("e_ovf", Ovf, 0);
    E = 1; In = 8'h00;
    Rdy = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("d_v_end", V, 0);
    chk("d_pend_end", Pend, 8'h00);

    // 6: mid-operation reset discards everything
    Rdy = 0; In = 8'h0F;
    tick();
    In = 8'h00;
    tick();
    In = 8'h08;
    tick();
    In = 8'h00;
    chk("r_pend", Pend, 8'h0F);
    chk("r_out", {V, Out}, {1'b1, 3'd3});
    rst = 1;
    tick();
    rst = 0;
    q.delete();
    chk("r_v", V, 0);
    chk("r_pend0", Pend, 8'h00);
    chk("r_out0", Out, 0);
    Rdy = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r_quiet", V, 0);
    end

    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
